// File: rtl/wb_stage_ctrl_pkg.sv
// Shared instruction definitions and writeback select encodings for the W stage.
package wb_stage_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned LINK_OFFSET = 8;

    // Writeback data source
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_LINK = 2'd2
    } src_sel_e;

    // Load width / extension flavour
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_type_e;

endpackage

// File: rtl/wb_stage_ctrl_load_ext.sv
// Sub-word load extraction and sign/zero extension from a word-aligned read.
module wb_stage_ctrl_load_ext
    import wb_stage_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  ld_type_e    ld_type,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend per load type
    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        ext      = rdata;
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (ld_type)
            LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext = {24'd0, byte_sel};
            LD_H:    ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext = {16'd0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_ctrl.sv
// MIPS writeback stage: M/W register, writeback decode, register-file write and retire count.
module wb_stage_ctrl
    import wb_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned CNT_W      = 32,
    parameter bit          EN_SUBWORD = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m_valid,
    input  logic [31:0]       m_instr,
    input  logic [31:0]       m_pc,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              w_stall,
    input  logic              w_flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              w_valid,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_q,    pc_d;
    logic [DATA_W-1:0]  alu_q,   alu_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         off_q,   off_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               dec_we;
    logic [REG_AW-1:0]  dec_dest;
    src_sel_e           dec_src;
    ld_type_e           dec_ld;
    logic [DATA_W-1:0]  ld_word;
    logic [DATA_W-1:0]  wb_data;
    logic               wr_c;
    logic               unused_instr_bits;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign unused_instr_bits = ^{instr_q[25:21], instr_q[10:6]};

    // Next W register state: flush beats stall, stall holds, else load from M
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        if (valid_q && !w_stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (w_flush) begin
            valid_d = 1'b0;
        end else if (!w_stall) begin
            valid_d = m_valid;
            instr_d = m_instr;
            pc_d    = m_pc;
            alu_d   = m_alu;
            rdata_d = m_rdata;
            off_d   = m_alu[1:0];
        end
    end

    // W register and retire counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writeback decode: write enable, destination, data source, load flavour
    always_comb begin
        dec_we   = 1'b0;
        dec_dest = '0;
        dec_src  = SRC_ALU;
        dec_ld   = LD_W;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        dec_we   = 1'b1;
                        dec_dest = REG_AW'(instr_q[15:11]);
                    end
                    FN_JALR: begin
                        dec_we   = 1'b1;
                        dec_dest = REG_AW'(instr_q[15:11]);
                        dec_src  = SRC_LINK;
                    end
                    default: dec_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ORI, OP_LUI: begin
                dec_we   = 1'b1;
                dec_dest = REG_AW'(instr_q[20:16]);
            end
            OP_LW: begin
                dec_we   = 1'b1;
                dec_dest = REG_AW'(instr_q[20:16]);
                dec_src  = SRC_LOAD;
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                if (EN_SUBWORD) begin
                    dec_we   = 1'b1;
                    dec_dest = REG_AW'(instr_q[20:16]);
                    dec_src  = SRC_LOAD;
                    case (opcode)
                        OP_LB:   dec_ld = LD_B;
                        OP_LBU:  dec_ld = LD_BU;
                        OP_LH:   dec_ld = LD_H;
                        default: dec_ld = LD_HU;
                    endcase
                end
            end
            OP_JAL: begin
                dec_we   = 1'b1;
                dec_dest = REG_AW'(LINK_REG);
                dec_src  = SRC_LINK;
            end
            default: dec_we = 1'b0;
        endcase
    end

    wb_stage_ctrl_load_ext u_load_ext (
        .rdata   (rdata_q),
        .off     (off_q),
        .ld_type (dec_ld),
        .ext     (ld_word)
    );

    // Select writeback data; link address wraps at 32 bits
    always_comb begin
        wb_data = alu_q;
        case (dec_src)
            SRC_LOAD: wb_data = ld_word;
            SRC_LINK: wb_data = DATA_W'(pc_q + 32'(LINK_OFFSET));
            default:  wb_data = alu_q;
        endcase
    end

    // Writes to $0 are suppressed; address/data are zeroed when nothing is pending
    assign wr_c       = valid_q & dec_we & (dec_dest != '0);
    assign fwd_valid  = wr_c;
    assign fwd_addr   = wr_c ? dec_dest : '0;
    assign fwd_data   = wr_c ? wb_data  : '0;
    assign rf_we      = wr_c & ~w_stall;
    assign rf_waddr   = fwd_addr;
    assign rf_wdata   = fwd_data;
    assign w_valid    = valid_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Randomized and directed checks of wb_stage_ctrl against a behavioural writeback model.
module tb_wb_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_alu, m_rdata;
    logic        w_stall, w_flush;
    logic        rf_we, fwd_valid, w_valid;
    logic [4:0]  rf_waddr, fwd_addr;
    logic [31:0] rf_wdata, fwd_data, retire_cnt;

    always #5 clk = ~clk;

    wb_stage_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m_valid    (m_valid),
        .m_instr    (m_instr),
        .m_pc       (m_pc),
        .m_alu      (m_alu),
        .m_rdata    (m_rdata),
        .w_stall    (w_stall),
        .w_flush    (w_flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .w_valid    (w_valid),
        .retire_cnt (retire_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference view of what sits in W, plus the count of retired instructions
    bit        mv;
    bit [31:0] mi, mp, ma, mr;
    bit [31:0] mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected W-stage outputs from the instruction held in the model
    function automatic void model_out(output bit we, output bit fv,
                                      output bit [4:0] a, output bit [31:0] d);
        bit [5:0]  op   = mi[31:26];
        bit [5:0]  fn   = mi[5:0];
        bit [4:0]  rt   = mi[20:16];
        bit [4:0]  rd   = mi[15:11];
        int        kind = 0; // 0 none, 1 alu, 2 load, 3 link
        bit [4:0]  dest = 0;
        bit [31:0] val  = 0;
        bit [31:0] b, h;
        int        off  = int'(ma & 32'd3);
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin kind = 1; dest = rd; end
        else if (op == 6'h00 && fn == 6'h09)              begin kind = 3; dest = rd; end
        else if (op == 6'h08 || op == 6'h0d || op == 6'h0f) begin kind = 1; dest = rt; end
        else if (op == 6'h23 || op == 6'h20 || op == 6'h24 || op == 6'h21 || op == 6'h25)
            begin kind = 2; dest = rt; end
        else if (op == 6'h03) begin kind = 3; dest = 5'd31; end
        b = (mr >> (8 * off)) & 32'hFF;
        h = (mr >> (16 * (off / 2))) & 32'hFFFF;
        case (kind)
            1: val = ma;
            3: val = mp + 32'd8;
            2: begin
                case (op)
                    6'h23: val = mr;
                    6'h24: val = b;
                    6'h25: val = h;
                    6'h20: val = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
                    default: val = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
                endcase
            end
            default: val = 0;
        endcase
        fv = mv && kind != 0 && dest != 0;
        we = fv && !w_stall;
        a  = fv ? dest : 5'd0;
        d  = fv ? val  : 32'd0;
    endfunction

    task automatic compare_model();
        bit we, fv;
        bit [4:0] a;
        bit [31:0] d;
        model_out(we, fv, a, d);
        chk("rf_we",      rf_we,      we);
        chk("rf_waddr",   rf_waddr,   a);
        chk("rf_wdata",   rf_wdata,   d);
        chk("fwd_valid",  fwd_valid,  fv);
        chk("fwd_addr",   fwd_addr,   a);
        chk("fwd_data",   fwd_data,   d);
        chk("w_valid",    w_valid,    mv);
        chk("retire_cnt", retire_cnt, mcnt);
    endtask

    task automatic model_reset();
        mv = 0; mi = 0; mp = 0; ma = 0; mr = 0; mcnt = 0;
    endtask

    // Drive M inputs away from the active edge
    task automatic set_in(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                          input bit [31:0] alu, input bit [31:0] rd,
                          input bit st, input bit fl);
        @(negedge clk);
        m_valid = v; m_instr = ins; m_pc = pc; m_alu = alu; m_rdata = rd;
        w_stall = st; w_flush = fl;
        #1;
    endtask

    // Advance one edge and apply the stage rules to the model
    task automatic tick();
        @(posedge clk);
        if (mv && !w_stall) mcnt = mcnt + 1;
        if (w_flush) mv = 0;
        else if (!w_stall) begin
            mv = m_valid; mi = m_instr; mp = m_pc; ma = m_alu; mr = m_rdata;
        end
    endtask

    task automatic idle(input bit st, input bit fl);
        set_in(0, 32'h0, 32'h0, 32'h0, 32'h0, st, fl);
    endtask

    function automatic bit [31:0] rtype(input bit [4:0] rd, input bit [5:0] fn);
        bit [31:0] w = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0};
        w[15:11] = rd;
        w[5:0]   = fn;
        return w;
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] op, input bit [4:0] rt);
        bit [31:0] w = 32'h0000_1234;
        w[31:26] = op;
        w[25:21] = 5'd3;
        w[20:16] = rt;
        return w;
    endfunction

    function automatic bit [4:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    function automatic bit [31:0] rnd_instr();
        bit [31:0] w = $urandom;
        int k = $urandom_range(0, 17);
        bit [5:0] fns [5] = '{6'h21, 6'h23, 6'h08, 6'h09, 6'h2a};
        bit [5:0] ops [13] = '{6'h08, 6'h0d, 6'h0f, 6'h23, 6'h20, 6'h24, 6'h21,
                               6'h25, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
        if (k < 5) begin
            w[31:26] = 6'h00;
            w[5:0]   = fns[k];
            w[15:11] = rnd_reg();
        end else begin
            w[31:26] = ops[k-5];
            w[20:16] = rnd_reg();
        end
        return w;
    endfunction

    initial begin
        reset_n = 1'b0;
        m_valid = 0; m_instr = 0; m_pc = 0; m_alu = 0; m_rdata = 0;
        w_stall = 0; w_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare_model();
        reset_n = 1'b1;

        // addu rd=5
        set_in(1, rtype(5'd5, 6'h21), 32'h100, 32'h1234, 32'h0, 0, 0);
        compare_model(); tick();
        idle(0, 0);
        compare_model();
        chk("addu_we",    rf_we,    32'd1);
        chk("addu_waddr", rf_waddr, 32'd5);
        chk("addu_wdata", rf_wdata, 32'h0000_1234);
        chk("addu_cnt0",  retire_cnt, 32'd0);
        tick();

        // lb / lbu / lhu / jal / ori
        set_in(1, itype(6'h20, 5'd8), 32'h104, 32'h0000_1003, 32'h80FF_0000, 0, 0);
        compare_model();
        chk("addu_cnt1", retire_cnt, 32'd1);
        tick();
        set_in(1, itype(6'h24, 5'd8), 32'h108, 32'h0000_1003, 32'h80FF_0000, 0, 0);
        compare_model();
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        tick();
        set_in(1, itype(6'h25, 5'd9), 32'h10c, 32'h0000_2002, 32'hBEEF_0001, 0, 0);
        compare_model();
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        tick();
        set_in(1, {6'h03, 26'h0000C00}, 32'h3000, 32'h0, 32'h0, 0, 0);
        compare_model();
        chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
        tick();
        set_in(1, itype(6'h0d, 5'd3), 32'h3004, 32'h55, 32'h0, 0, 0);
        compare_model();
        chk("jal_waddr", rf_waddr, 32'd31);
        chk("jal_wdata", rf_wdata, 32'h0000_3008);
        tick();

        // Stall the ori for three cycles
        for (int i = 0; i < 3; i++) begin
            set_in(1, itype(6'h08, 5'd12), 32'h3008, 32'h77, 32'h0, 1, 0);
            compare_model();
            chk("stall_fwd",  fwd_valid,  32'd1);
            chk("stall_we",   rf_we,      32'd0);
            chk("stall_cnt",  retire_cnt, 32'd5);
            tick();
        end
        idle(0, 0);
        compare_model();
        chk("release_we",    rf_we,    32'd1);
        chk("release_waddr", rf_waddr, 32'd3);
        tick();
        idle(0, 0);
        chk("release_cnt", retire_cnt, 32'd6);
        tick();

        // Flush together with stall discards a valid addu
        set_in(1, rtype(5'd7, 6'h21), 32'h200, 32'hAA, 32'h0, 0, 0);
        compare_model(); tick();
        set_in(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
        compare_model(); tick();
        idle(0, 0);
        compare_model();
        chk("flush_valid", w_valid,    32'd0);
        chk("flush_we",    rf_we,      32'd0);
        chk("flush_cnt",   retire_cnt, 32'd6);
        tick();

        // addu to $0: no write, still retired
        set_in(1, rtype(5'd0, 6'h21), 32'h204, 32'hBB, 32'h0, 0, 0);
        compare_model(); tick();
        idle(0, 0);
        compare_model();
        chk("zero_we",  rf_we,     32'd0);
        chk("zero_fwd", fwd_valid, 32'd0);
        tick();
        idle(0, 0);
        chk("zero_cnt", retire_cnt, 32'd7);
        tick();

        // Async reset while a stalled lw is pending
        set_in(1, itype(6'h23, 5'd4), 32'h300, 32'h40, 32'hDEAD_BEEF, 0, 0);
        compare_model(); tick();
        idle(1, 0);
        compare_model();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_we",    rf_we,      32'd0);
        chk("rst_waddr", rf_waddr,   32'd0);
        chk("rst_wdata", rf_wdata,   32'd0);
        chk("rst_fwd",   fwd_valid,  32'd0);
        chk("rst_faddr", fwd_addr,   32'd0);
        chk("rst_fdata", fwd_data,   32'd0);
        chk("rst_valid", w_valid,    32'd0);
        chk("rst_cnt",   retire_cnt, 32'd0);
        model_reset();
        reset_n = 1'b1;
        tick();
        idle(0, 0);
        compare_model();
        chk("post_rst_we", rf_we, 32'd0);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 9) != 0), rnd_instr(), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            compare_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage_ctrl.md
# wb_stage_ctrl

Parametrised writeback stage for the five-stage MIPS pipeline: it holds the M/W pipeline register and decodes writeback control (write enable, destination, source select). It extends sub-word loads, produces the register-file write port and the W-stage forwarding source, and counts retired instructions. The block sits between the data-memory stage and the register file, and replaces the purely combinational W-stage decoder.

## Interface
Parameters:
- DATA_W, 32: datapath width; must be 32.
- REG_AW, 5: register address width.
- LINK_REG, 31: destination register of jal.
- CNT_W, 32: width of the retire counter.
- EN_SUBWORD, 1: when 1, lb/lbu/lh/lhu are decoded. When 0, they are treated as no-write.

Ports:
- clk in 1: single clock, rising edge.
- reset_n in 1: asynchronous, active-low reset.
- m_valid in 1: the M stage holds a real instruction.
- m_instr in 32: M-stage instruction word.
- m_pc in 32: M-stage PC.
- m_alu in DATA_W: ALU result. For loads this is the effective address.
- m_rdata in DATA_W: data-memory read word (word-aligned).
- w_stall in 1: hold the W register.
- w_flush in 1: invalidate the W register.
- rf_we out 1: register-file write strobe.
- rf_waddr out REG_AW: write address.
- rf_wdata out DATA_W: write data.
- fwd_valid out 1: W holds a pending result usable for forwarding.
- fwd_addr out REG_AW: forwarding address.
- fwd_data out DATA_W: forwarding data.
- w_valid out 1: the W register holds a valid instruction.
- retire_cnt out CNT_W: number of retired instructions.

## Operation
- W register fields: valid, instr, pc, alu, rdata, byte offset (m_alu[1:0]).
- Decode set:
  - addu, subu, jalr: write to rd.
  - addi, ori, lui, lw, lb, lbu, lh, lhu: write to rt.
  - jal: writes LINK_REG.
  - sw, beq, j, jr, and any unrecognised encoding: no write.
- Source select:
  - ALU (addu, subu, addi, ori, lui) → alu.
  - Load (lw, lb, lbu, lh, lhu) → extended rdata.
  - Link (jal, jalr) → pc+8 (32-bit wrap).
- Load extension, with off = byte offset:
  - lw: the whole word.
  - lb/lbu: byte `rdata[8*off+7 : 8*off]`; lb sign-extends, lbu zero-extends.
  - lh/lhu: halfword selected by off[1] only (off[0] is ignored); lh sign-extends, lhu zero-extends.
- `wr = w_valid & decoded_write & (dest != 0)`. Writes to $0 never assert rf_we or fwd_valid.
- `fwd_valid = wr`. fwd_addr and fwd_data equal rf_waddr and rf_wdata.
- `rf_we = wr & ~w_stall`. Each instruction is written exactly once, in the cycle it leaves W.
- `retire = w_valid & ~w_stall`. retire_cnt increments on that edge and wraps modulo 2^CNT_W. Non-writing instructions also count.
- When rf_we is 0, rf_waddr and rf_wdata are don't-care but must not be X.

## Timing
- Latency: inputs sampled at edge N appear on rf_*, fwd_*, and w_valid after edge N. All of these are combinational from the W register.
- Edge update priority:
  1. Reset (async): all W fields, valid, and retire_cnt go to 0, so every output reads 0.
  2. w_flush: valid goes to 0; other fields are don't-care.
  3. w_stall: all fields hold.
  4. Otherwise: load from the M inputs, with valid = m_valid.
- Flush with stall together: the flush wins. The stalled instruction is discarded, is not written, and is not counted.
- Retire counting uses the pre-edge w_valid, so a flushed-while-stalled instruction is not counted.
- Reset asserted mid-stall: the pending write is lost, and no rf_we is issued after reset deasserts until a new valid instruction arrives.
- Reset deassertion is used synchronously by the surrounding logic. The block places no requirement on it.

## Structure
- Opcode and funct constants go in the shared instruction-definition header: RTYPE, ADDU, SUBU, JR, JALR, ADDI, ORI, LW, LB, LBU, LH, LHU, SW, BEQ, LUI, J, JAL. Source-select encodings (ALU=0, LOAD=1, LINK=2) also go there.
- Sub-module `load_ext`: purely combinational; inputs rdata, off, load type; output extended word.
- Decoder and W register stay in this module.

## Test plan
- Basic write: addu with rd=5 and alu=0x1234, m_valid=1, no stall. Next cycle: rf_we=1, waddr=5, wdata=0x00001234, and retire_cnt goes 0 → 1.
- Signed byte load: lb with rt=8, alu=...3, rdata=0x80FF_0000. Response: wdata=0xFFFFFF80. Same stimulus as lbu: wdata=0x00000080.
- Halfword and link:
  - lhu, off=2, rdata=0xBEEF_0001 → wdata=0x0000BEEF.
  - jal at pc=0x3000 → waddr=31, wdata=0x3008.
- Stall: w_stall held for 3 cycles with an ori in W. Response:
  - fwd_valid=1 throughout.
  - rf_we=0 during the stall.
  - One rf_we pulse on release.
  - retire_cnt increments by exactly 1.
- Flush and $0:
  - w_flush with w_stall on a valid addu → no write, no count.
  - addu with rd=0 → rf_we=0, fwd_valid=0, but the count increments.
- Reset: drop reset_n between clock edges while W holds a valid lw. Response: all outputs read 0 immediately, and retire_cnt reads 0.
